// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection LED bus: rebuilds the 6-phase light
// sequence and flags illegal/unsafe lamp patterns and sequence or dwell faults.
// Build option: define TLM_AUTO_RELOCK_EN to resynchronise after an error
// instead of halting in ERROR until reset.
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 15,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 3,
  parameter int CNT_W      = 4,
  parameter int CYC_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       LED_NS,
  input  logic [2:0]       LED_WE,
  output logic             locked,
  output logic [2:0]       phase,
  output logic             err,
  output logic [2:0]       err_code,
  output logic [CYC_W-1:0] cycle_cnt
);

  typedef enum logic [1:0] {SYNC, TRACK, ERROR} state_t;

  localparam logic [2:0] PAT_INV = 3'd0;
  localparam logic [2:0] PAT_GR  = 3'd1;
  localparam logic [2:0] PAT_YR  = 3'd2;
  localparam logic [2:0] PAT_RR  = 3'd3;
  localparam logic [2:0] PAT_RG  = 3'd4;
  localparam logic [2:0] PAT_RY  = 3'd5;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_ILLEGAL  = 3'd1;
  localparam logic [2:0] E_CONFLICT = 3'd2;
  localparam logic [2:0] E_SEQ      = 3'd3;
  localparam logic [2:0] E_SHORT    = 3'd4;
  localparam logic [2:0] E_LONG     = 3'd5;

`ifdef TLM_AUTO_RELOCK_EN
  localparam state_t ERR_NEXT = SYNC;
`else
  localparam state_t ERR_NEXT = ERROR;
`endif

  state_t           r_state;
  logic [2:0]       r_prev_pat;
  logic [2:0]       r_phase;
  logic [CNT_W-1:0] r_dwell;
  logic             r_locked;
  logic             r_err;
  logic [2:0]       r_err_code;
  logic [CYC_W-1:0] r_cycle_cnt;

  logic             w_illegal;
  logic             w_conflict;
  logic [2:0]       w_pat;
  logic [2:0]       w_next_phase;
  logic [2:0]       w_cur_pat;
  logic [2:0]       w_next_pat;
  logic [CNT_W-1:0] w_exp_dwell;
  logic [2:0]       w_code;

  function automatic logic [2:0] phase_pat(input logic [2:0] p);
    case (p)
      3'd0:    phase_pat = PAT_GR;
      3'd1:    phase_pat = PAT_YR;
      3'd2:    phase_pat = PAT_RR;
      3'd3:    phase_pat = PAT_RG;
      3'd4:    phase_pat = PAT_RY;
      3'd5:    phase_pat = PAT_RR;
      default: phase_pat = PAT_INV;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] phase_dwell(input logic [2:0] p);
    case (p)
      3'd0, 3'd3: phase_dwell = CNT_W'(GREEN_CYC);
      3'd1, 3'd4: phase_dwell = CNT_W'(YELLOW_CYC);
      default:    phase_dwell = CNT_W'(ALLRED_CYC);
    endcase
  endfunction

  assign w_illegal    = !($onehot(LED_NS) && $onehot(LED_WE));
  assign w_conflict   = !w_illegal && (LED_NS != 3'b100) && (LED_WE != 3'b100);
  assign w_next_phase = (r_phase == 3'd5) ? 3'd0 : r_phase + 3'd1;
  assign w_cur_pat    = phase_pat(r_phase);
  assign w_next_pat   = phase_pat(w_next_phase);
  assign w_exp_dwell  = phase_dwell(r_phase);

  // Legal, non-conflicting samples always have at least one red lamp
  always_comb begin
    w_pat = PAT_INV;
    case ({LED_NS, LED_WE})
      6'b001_100: w_pat = PAT_GR;
      6'b010_100: w_pat = PAT_YR;
      6'b100_100: w_pat = PAT_RR;
      6'b100_001: w_pat = PAT_RG;
      6'b100_010: w_pat = PAT_RY;
      default:    w_pat = PAT_INV;
    endcase
  end

  // Error detection in priority order; ERROR ignores all further faults
  always_comb begin
    w_code = E_NONE;
    if (r_state != ERROR) begin
      if (w_illegal)
        w_code = E_ILLEGAL;
      else if (w_conflict)
        w_code = E_CONFLICT;
      else if (r_state == TRACK) begin
        if (w_pat == w_cur_pat) begin
          if (r_dwell == w_exp_dwell)
            w_code = E_LONG;
        end else if (w_pat != w_next_pat)
          w_code = E_SEQ;
        else if (r_dwell < w_exp_dwell)
          w_code = E_SHORT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SYNC;
      r_prev_pat  <= PAT_INV;
      r_phase     <= 3'd7;
      r_dwell     <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= E_NONE;
      r_cycle_cnt <= '0;
    end else begin
      r_prev_pat <= w_pat;
      if (w_code != E_NONE) begin
        r_err <= 1'b1;
        if (r_err_code == E_NONE)
          r_err_code <= w_code;
        r_locked <= 1'b0;
        r_phase  <= 3'd7;
        r_dwell  <= '0;
        r_state  <= ERR_NEXT;
      end else begin
        case (r_state)
          SYNC: begin
            if (r_prev_pat == PAT_RR && (w_pat == PAT_GR || w_pat == PAT_RG)) begin
              r_phase  <= (w_pat == PAT_GR) ? 3'd0 : 3'd3;
              r_dwell  <= CNT_W'(1);
              r_locked <= 1'b1;
              r_state  <= TRACK;
            end
          end
          TRACK: begin
            if (w_pat == w_cur_pat) begin
              r_dwell <= r_dwell + CNT_W'(1);
            end else begin
              r_phase <= w_next_phase;
              r_dwell <= CNT_W'(1);
              if (r_phase == 3'd5 && r_cycle_cnt != '1)
                r_cycle_cnt <= r_cycle_cnt + CYC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign locked    = r_locked;
  assign phase     = r_phase;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: a table of single-fault vectors
// plus hand-written multi-cycle sequences (full periods, dwell, reset, relock).
module tb_traffic_light_monitor;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] LED_NS = R;
  logic [2:0] LED_WE = R;
  logic       locked;
  logic [2:0] phase;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .LED_NS(LED_NS), .LED_WE(LED_WE),
    .locked(locked), .phase(phase), .err(err), .err_code(err_code),
    .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         setup;
    logic [2:0] ns;
    logic [2:0] we;
    logic       exp_locked;
    logic [2:0] exp_phase;
    logic [2:0] exp_code;
  } vec_t;

  vec_t vecs[15];

  task automatic set_vec(input int idx, input string name, input int setup,
                         input logic [2:0] ns, input logic [2:0] we,
                         input logic lk, input logic [2:0] ph, input logic [2:0] code);
    vecs[idx].name       = name;
    vecs[idx].setup      = setup;
    vecs[idx].ns         = ns;
    vecs[idx].we         = we;
    vecs[idx].exp_locked = lk;
    vecs[idx].exp_phase  = ph;
    vecs[idx].exp_code   = code;
  endtask

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs read 1 unit after the next edge
  task automatic drive(input logic [2:0] ns, input logic [2:0] we, input int n);
    for (int i = 0; i < n; i++) begin
      LED_NS = ns;
      LED_WE = we;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_chk(input logic [2:0] ns, input logic [2:0] we, input int n,
                           input int ph);
    for (int i = 0; i < n; i++) begin
      drive(ns, we, 1);
      check("track_phase", int'(phase), ph);
      check("track_locked", int'(locked), 1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic full_period();
    drive(G, R, 15); drive(Y, R, 3); drive(R, R, 3);
    drive(R, G, 15); drive(R, Y, 3); drive(R, R, 3);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_phase"}, int'(phase), 7);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_code"}, int'(err_code), 0);
    check({tag, "_cnt"}, int'(cycle_cnt), 0);
  endtask

  initial begin
    set_vec(0,  "lock_gr",        0,  G,    R, 1'b1, 3'd0, 3'd0);
    set_vec(1,  "lock_rg",        0,  R,    G, 1'b1, 3'd3, 3'd0);
    set_vec(2,  "sync_no_lock",   0,  R,    R, 1'b0, 3'd7, 3'd0);
    set_vec(3,  "sync_illegal",   0,  3'b011, R, 1'b0, 3'd7, 3'd1);
    set_vec(4,  "sync_conflict",  0,  Y,    G, 1'b0, 3'd7, 3'd2);
    set_vec(5,  "p0_conflict",    3,  G,    G, 1'b0, 3'd7, 3'd2);
    set_vec(6,  "p0_illegal",     3,  3'b011, R, 1'b0, 3'd7, 3'd1);
    set_vec(7,  "p0_zero_code",   2,  3'b000, R, 1'b0, 3'd7, 3'd1);
    set_vec(8,  "illegal_first",  3,  3'b011, G, 1'b0, 3'd7, 3'd1);
    set_vec(9,  "seq_ry",         5,  R,    Y, 1'b0, 3'd7, 3'd3);
    set_vec(10, "seq_over_short", 5,  R,    R, 1'b0, 3'd7, 3'd3);
    set_vec(11, "short_14",       14, Y,    R, 1'b0, 3'd7, 3'd4);
    set_vec(12, "short_1",        1,  Y,    R, 1'b0, 3'd7, 3'd4);
    set_vec(13, "long_green",     15, G,    R, 1'b0, 3'd7, 3'd5);
    set_vec(14, "p0_to_p1",       15, Y,    R, 1'b1, 3'd1, 3'd0);

    // Test 1: reset state, three valid periods, cycle counting
    do_reset();
    check_reset_state("rst");
    drive(R, R, 1);
    check("pre_lock_locked", int'(locked), 0);
    check("pre_lock_phase", int'(phase), 7);
    for (int p = 0; p < 3; p++) begin
      drive_chk(G, R, 15, 0); drive_chk(Y, R, 3, 1); drive_chk(R, R, 3, 2);
      drive_chk(R, G, 15, 3); drive_chk(R, Y, 3, 4); drive_chk(R, R, 3, 5);
      check("period_cnt", int'(cycle_cnt), p);
    end
    drive_chk(G, R, 1, 0);
    check("t1_cnt", int'(cycle_cnt), 3);
    check("t1_err", int'(err), 0);
    $display("seq valid_periods: cnt=%0d err=%0d", cycle_cnt, err);

    // Single-fault table
    for (int v = 0; v < 15; v++) begin
      do_reset();
      drive(R, R, 1);
      drive(G, R, vecs[v].setup);
      drive(vecs[v].ns, vecs[v].we, 1);
      check({vecs[v].name, "_locked"}, int'(locked), int'(vecs[v].exp_locked));
      check({vecs[v].name, "_phase"}, int'(phase), int'(vecs[v].exp_phase));
      check({vecs[v].name, "_code"}, int'(err_code), int'(vecs[v].exp_code));
      check({vecs[v].name, "_err"}, int'(err), int'(vecs[v].exp_code != 3'd0));
      $display("vec %0d %s: locked=%0d phase=%0d err=%0d code=%0d",
               v, vecs[v].name, locked, phase, err, err_code);
    end

    // Test 3: yellow held one sample too long
    do_reset();
    drive(R, R, 1);
    drive(G, R, 15);
    drive(Y, R, 3);
    check("y3_err", int'(err), 0);
    check("y3_phase", int'(phase), 1);
    drive(Y, R, 1);
    check("ylong_err", int'(err), 1);
    check("ylong_code", int'(err_code), 5);
    check("ylong_locked", int'(locked), 0);
    $display("seq yellow_long: code=%0d", err_code);

    // Test 5: skipped R/G after P2, then relock attempt and first-error hold
    do_reset();
    drive(R, R, 1);
    drive(G, R, 15); drive(Y, R, 3); drive(R, R, 3);
    drive(G, R, 1);
    check("skip_code", int'(err_code), 3);
    check("skip_phase", int'(phase), 7);
    drive(R, R, 3);
    drive(G, R, 1);
`ifdef TLM_AUTO_RELOCK_EN
    check("relock_locked", int'(locked), 1);
    check("relock_phase", int'(phase), 0);
`else
    check("relock_locked", int'(locked), 0);
    check("relock_phase", int'(phase), 7);
`endif
    check("relock_code", int'(err_code), 3);
    drive(G, G, 1);
    check("second_err_code", int'(err_code), 3);
    check("second_err_locked", int'(locked), 0);
    check("second_err_err", int'(err), 1);
    $display("seq skip_relock: locked=%0d code=%0d", locked, err_code);

    // Test 6: reset mid-P3 with cycle_cnt=2, then no lock without a fresh R/R edge
    do_reset();
    drive(R, R, 1);
    full_period();
    full_period();
    drive(G, R, 15); drive(Y, R, 3); drive(R, R, 3); drive(R, G, 5);
    check("mid_p3_cnt", int'(cycle_cnt), 2);
    check("mid_p3_phase", int'(phase), 3);
    do_reset();
    check_reset_state("midrst");
    drive(R, G, 2);
    check("no_relock_locked", int'(locked), 0);
    $display("seq mid_reset: locked=%0d cnt=%0d", locked, cycle_cnt);

    // Reset after an error clears the sticky flags
    drive(G, G, 1);
    check("pre_rst_err", int'(err), 1);
    do_reset();
    check_reset_state("errrst");
    $display("seq error_reset: err=%0d code=%0d", err, err_code);

    // cycle_cnt saturates at all-ones
    drive(R, R, 1);
    for (int p = 0; p < 255; p++) full_period();
    drive(G, R, 1);
    check("cnt_255", int'(cycle_cnt), 255);
    drive(G, R, 14); drive(Y, R, 3); drive(R, R, 3);
    drive(R, G, 15); drive(R, Y, 3); drive(R, R, 3);
    drive(G, R, 1);
    check("cnt_sat", int'(cycle_cnt), 255);
    check("cnt_sat_err", int'(err), 0);
    $display("seq saturate: cnt=%0d", cycle_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
